inv_shift_rows_serial: RTL and testbench

Byte-serial AES (Inv)ShiftRows engine for the decryption datapath. It accepts a 128-bit state as 16 bytes in state order (byte 0 = Stin[0:7] first, column-major: byte i = row i%4, column i/4) and emits the permuted state as 16 bytes. Two 16-byte ping-pong buffers sustain one byte per cycle in both directions. It sits between the byte-serial InvSubBytes stage and AddRoundKey; with INVERSE=0 it serves the encryption path.

---
 rtl/inv_shift_rows_serial.sv | 78 +++++++
 tb/tb_inv_shift_rows_serial.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inv_shift_rows_serial.sv
// Byte-serial AES (Inv)ShiftRows: two 16-byte ping-pong buffers.
// Bytes are written in state order and read back in permuted order.
//
// buffer state | meaning
// EMPTY        | full[b]=0, write side fills it via wcnt
// FULL         | full[b]=1, read side drains it via rcnt
module inv_shift_rows_serial #(
  parameter bit INVERSE = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] din,
  input  logic       din_valid,
  output logic       din_ready,
  output logic [7:0] dout,
  output logic       dout_valid,
  input  logic       dout_ready,
  output logic       dout_last
);

  logic [7:0] mem [2][16];
  logic [1:0] full;
  logic [1:0] full_nxt;
  logic       wsel;
  logic       rsel;
  logic [3:0] wcnt;
  logic [3:0] rcnt;
  logic       wr_fire;
  logic       rd_fire;
  logic [1:0] scol;
  logic [3:0] sidx;

  assign din_ready  = ~full[wsel];
  assign dout_valid = full[rsel];
  assign dout_last  = dout_valid & (rcnt == 4'd15);
  assign wr_fire    = din_valid & din_ready;
  assign rd_fire    = dout_valid & dout_ready;

  // Output byte (c, r) comes from column c-r (inverse) or c+r (forward) of row r.
  // The 2-bit column arithmetic wraps mod 4 on its own.
  assign scol = INVERSE ? (rcnt[3:2] - rcnt[1:0]) : (rcnt[3:2] + rcnt[1:0]);
  assign sidx = {scol, rcnt[1:0]};
  assign dout = dout_valid ? mem[rsel][sidx] : 8'h00;

  // Both sides can finish a block on the same edge; they never touch the
  // same buffer then, so both flag updates apply.
  always_comb begin
    full_nxt = full;
    if (wr_fire && (wcnt == 4'd15)) full_nxt[wsel] = 1'b1;
    if (rd_fire && (rcnt == 4'd15)) full_nxt[rsel] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full <= 2'b00;
      wsel <= 1'b0;
      rsel <= 1'b0;
      wcnt <= 4'd0;
      rcnt <= 4'd0;
    end else begin
      full <= full_nxt;
      if (wr_fire) begin
        wcnt <= wcnt + 4'd1;
        if (wcnt == 4'd15) wsel <= ~wsel;
      end
      if (rd_fire) begin
        rcnt <= rcnt + 4'd1;
        if (rcnt == 4'd15) rsel <= ~rsel;
      end
    end
  end

  // Storage is not reset; stale contents stay hidden behind full=00.
  always_ff @(posedge clk) begin
    if (wr_fire) mem[wsel][wcnt] <= din;
  end

endmodule

// File: tb/tb_inv_shift_rows_serial.sv
// Directed bench for inv_shift_rows_serial: permutation order, throughput,
// backpressure, reset and a forward->inverse round trip.
module tb_inv_shift_rows_serial;

  logic       clk;
  logic       rst;
  logic [7:0] din;
  logic       din_valid;
  logic       dout_ready;
  logic       inv_din_ready, fwd_din_ready;
  logic [7:0] inv_dout, fwd_dout;
  logic       inv_dout_valid, fwd_dout_valid;
  logic       inv_dout_last, fwd_dout_last;

  logic [7:0] rt_din;
  logic       rt_din_valid, rt_din_ready;
  logic [7:0] mid_dout;
  logic       mid_valid, mid_ready, mid_last;
  logic [7:0] rt_out;
  logic       rt_out_valid, rt_out_ready, rt_out_last;

  int pass_cnt = 0;
  int total_cnt = 0;

  int idx_inv [16] = '{0, 13, 10, 7, 4, 1, 14, 11, 8, 5, 2, 15, 12, 9, 6, 3};
  int idx_fwd [16] = '{0, 5, 10, 15, 4, 9, 14, 3, 8, 13, 2, 7, 12, 1, 6, 11};

  inv_shift_rows_serial #(.INVERSE(1'b1)) u_inv (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(inv_din_ready),
    .dout(inv_dout), .dout_valid(inv_dout_valid), .dout_ready(dout_ready), .dout_last(inv_dout_last));

  inv_shift_rows_serial #(.INVERSE(1'b0)) u_fwd (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(fwd_din_ready),
    .dout(fwd_dout), .dout_valid(fwd_dout_valid), .dout_ready(dout_ready), .dout_last(fwd_dout_last));

  inv_shift_rows_serial #(.INVERSE(1'b0)) u_rt_fwd (
    .clk(clk), .rst(rst), .din(rt_din), .din_valid(rt_din_valid), .din_ready(rt_din_ready),
    .dout(mid_dout), .dout_valid(mid_valid), .dout_ready(mid_ready), .dout_last(mid_last));

  inv_shift_rows_serial #(.INVERSE(1'b1)) u_rt_inv (
    .clk(clk), .rst(rst), .din(mid_dout), .din_valid(mid_valid), .din_ready(mid_ready),
    .dout(rt_out), .dout_valid(rt_out_valid), .dout_ready(rt_out_ready), .dout_last(rt_out_last));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] dat(input int n);
    logic [7:0] v;
    v = n[7:0] * 8'd7 + 8'd49;
    return v;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    din_valid = 1'b0;
    rt_din_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total_cnt++; if (inv_din_ready !== 1'b1) $display("FAIL reset_din_ready: got %b want 1", inv_din_ready); else pass_cnt++;
    total_cnt++; if (inv_dout_valid !== 1'b0) $display("FAIL reset_dout_valid: got %b want 0", inv_dout_valid); else pass_cnt++;
    total_cnt++; if (inv_dout !== 8'h00) $display("FAIL reset_dout: got %h want 00", inv_dout); else pass_cnt++;
    total_cnt++; if (inv_dout_last !== 1'b0) $display("FAIL reset_dout_last: got %b want 0", inv_dout_last); else pass_cnt++;
    total_cnt++; if (u_inv.full !== 2'b00) $display("FAIL reset_full: got %b want 00", u_inv.full); else pass_cnt++;
    total_cnt++; if (fwd_din_ready !== 1'b1) $display("FAIL reset_fwd_din_ready: got %b want 1", fwd_din_ready); else pass_cnt++;
    total_cnt++; if (fwd_dout_valid !== 1'b0) $display("FAIL reset_fwd_dout_valid: got %b want 0", fwd_dout_valid); else pass_cnt++;
  endtask

  // Feeds 00..0F to both instances and checks the two permutation orders.
  task automatic test_order();
    do_reset();
    dout_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      din = 8'(i);
      din_valid = 1'b1;
      total_cnt++; if (inv_dout_valid !== 1'b0) $display("FAIL order_early_valid byte %0d: got %b want 0", i, inv_dout_valid); else pass_cnt++;
    end
    @(negedge clk);
    din_valid = 1'b0;
    for (int k = 0; k < 16; k++) begin
      total_cnt++; if (inv_dout_valid !== 1'b1) $display("FAIL order_inv_valid k=%0d: got %b want 1", k, inv_dout_valid); else pass_cnt++;
      total_cnt++; if (inv_dout !== 8'(idx_inv[k])) $display("FAIL order_inv_dout k=%0d: got %h want %h", k, inv_dout, 8'(idx_inv[k])); else pass_cnt++;
      total_cnt++; if (inv_dout_last !== (k == 15)) $display("FAIL order_inv_last k=%0d: got %b want %b", k, inv_dout_last, (k == 15)); else pass_cnt++;
      total_cnt++; if (fwd_dout !== 8'(idx_fwd[k])) $display("FAIL order_fwd_dout k=%0d: got %h want %h", k, fwd_dout, 8'(idx_fwd[k])); else pass_cnt++;
      total_cnt++; if (fwd_dout_last !== (k == 15)) $display("FAIL order_fwd_last k=%0d: got %b want %b", k, fwd_dout_last, (k == 15)); else pass_cnt++;
      @(negedge clk);
    end
    total_cnt++; if (inv_dout_valid !== 1'b0) $display("FAIL order_drained: got %b want 0", inv_dout_valid); else pass_cnt++;
  endtask

  // Three blocks streamed with no gaps; block 2's last write meets block 1's last read.
  task automatic test_back_to_back();
    do_reset();
    dout_ready = 1'b1;
    fork
      begin
        for (int n = 0; n < 48; n++) begin
          @(negedge clk);
          din = dat(n);
          din_valid = 1'b1;
          total_cnt++; if (inv_din_ready !== 1'b1) $display("FAIL b2b_din_ready n=%0d: got %b want 1", n, inv_din_ready); else pass_cnt++;
        end
        @(negedge clk);
        din_valid = 1'b0;
      end
      begin
        int waited;
        waited = 0;
        @(negedge clk);
        while (!inv_dout_valid && waited < 40) begin
          @(negedge clk);
          waited++;
        end
        total_cnt++; if (waited !== 16) $display("FAIL b2b_latency: got %0d cycles want 16", waited); else pass_cnt++;
        for (int k = 0; k < 48; k++) begin
          if (k == 15) begin
            total_cnt++; if (u_inv.full !== 2'b01) $display("FAIL b2b_full_before: got %b want 01", u_inv.full); else pass_cnt++;
          end
          if (k == 16) begin
            total_cnt++; if (u_inv.full !== 2'b10) $display("FAIL b2b_full_after: got %b want 10", u_inv.full); else pass_cnt++;
          end
          total_cnt++; if (inv_dout_valid !== 1'b1) $display("FAIL b2b_valid k=%0d: got %b want 1", k, inv_dout_valid); else pass_cnt++;
          total_cnt++; if (inv_dout !== dat((k / 16) * 16 + idx_inv[k % 16])) $display("FAIL b2b_dout k=%0d: got %h want %h", k, inv_dout, dat((k / 16) * 16 + idx_inv[k % 16])); else pass_cnt++;
          @(negedge clk);
        end
      end
    join
  endtask

  task automatic test_backpressure();
    int acc;
    do_reset();
    dout_ready = 1'b0;
    acc = 0;
    for (int n = 0; n < 48; n++) begin
      @(negedge clk);
      din = dat(n);
      din_valid = 1'b1;
      if (inv_din_ready) acc++;
    end
    @(negedge clk);
    din_valid = 1'b0;
    total_cnt++; if (acc !== 32) $display("FAIL bp_accepted: got %0d want 32", acc); else pass_cnt++;
    total_cnt++; if (inv_din_ready !== 1'b0) $display("FAIL bp_din_ready: got %b want 0", inv_din_ready); else pass_cnt++;
    repeat (3) begin
      total_cnt++; if (inv_dout_valid !== 1'b1) $display("FAIL bp_hold_valid: got %b want 1", inv_dout_valid); else pass_cnt++;
      total_cnt++; if (inv_dout !== dat(idx_inv[0])) $display("FAIL bp_hold_dout: got %h want %h", inv_dout, dat(idx_inv[0])); else pass_cnt++;
      @(negedge clk);
    end
    dout_ready = 1'b1;
    fork
      begin
        int n, cyc;
        logic a;
        n = 32;
        cyc = 0;
        while (n < 48 && cyc < 300) begin
          din = dat(n);
          din_valid = 1'b1;
          a = inv_din_ready;
          @(negedge clk);
          if (a) n++;
          cyc++;
        end
        din_valid = 1'b0;
        total_cnt++; if (n !== 48) $display("FAIL bp_refill: got %0d bytes want 48", n); else pass_cnt++;
      end
      begin
        int k, cyc;
        k = 0;
        cyc = 0;
        while (k < 48 && cyc < 300) begin
          if (inv_dout_valid) begin
            total_cnt++; if (inv_dout !== dat((k / 16) * 16 + idx_inv[k % 16])) $display("FAIL bp_dout k=%0d: got %h want %h", k, inv_dout, dat((k / 16) * 16 + idx_inv[k % 16])); else pass_cnt++;
            k++;
          end
          @(negedge clk);
          cyc++;
        end
        total_cnt++; if (k !== 48) $display("FAIL bp_drain: got %0d bytes want 48", k); else pass_cnt++;
      end
    join
  endtask

  task automatic test_reset_mid_block();
    do_reset();
    dout_ready = 1'b1;
    for (int n = 0; n < 7; n++) begin
      @(negedge clk);
      din = dat(100 + n);
      din_valid = 1'b1;
    end
    @(negedge clk);
    din_valid = 1'b0;
    rst = 1'b1;
    total_cnt++; if (inv_dout_valid !== 1'b0) $display("FAIL rmid_valid_during: got %b want 0", inv_dout_valid); else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    total_cnt++; if (inv_dout_valid !== 1'b0) $display("FAIL rmid_valid_after: got %b want 0", inv_dout_valid); else pass_cnt++;
    total_cnt++; if (inv_din_ready !== 1'b1) $display("FAIL rmid_din_ready: got %b want 1", inv_din_ready); else pass_cnt++;
    for (int n = 0; n < 16; n++) begin
      din = dat(200 + n);
      din_valid = 1'b1;
      @(negedge clk);
      if (n < 15) begin
        total_cnt++; if (inv_dout_valid !== 1'b0) $display("FAIL rmid_early_valid n=%0d: got %b want 0", n, inv_dout_valid); else pass_cnt++;
      end
    end
    din_valid = 1'b0;
    for (int k = 0; k < 16; k++) begin
      total_cnt++; if (inv_dout_valid !== 1'b1) $display("FAIL rmid_valid k=%0d: got %b want 1", k, inv_dout_valid); else pass_cnt++;
      total_cnt++; if (inv_dout !== dat(200 + idx_inv[k])) $display("FAIL rmid_dout k=%0d: got %h want %h", k, inv_dout, dat(200 + idx_inv[k])); else pass_cnt++;
      @(negedge clk);
    end
    repeat (4) begin
      total_cnt++; if (inv_dout_valid !== 1'b0) $display("FAIL rmid_leftover: got %b want 0", inv_dout_valid); else pass_cnt++;
      @(negedge clk);
    end
  endtask

  // Forward then inverse must reproduce the input stream exactly.
  task automatic test_round_trip();
    logic [7:0] stim [1600];
    for (int i = 0; i < 1600; i++) stim[i] = 8'($urandom_range(0, 255));
    do_reset();
    rt_out_ready = 1'b0;
    fork
      begin
        int n, cyc;
        logic a;
        n = 0;
        cyc = 0;
        while (n < 1600 && cyc < 20000) begin
          rt_din = stim[n];
          rt_din_valid = ($urandom_range(0, 3) != 0);
          a = rt_din_valid & rt_din_ready;
          @(negedge clk);
          if (a) n++;
          cyc++;
        end
        rt_din_valid = 1'b0;
      end
      begin
        int k, m, cyc;
        k = 0;
        m = 0;
        cyc = 0;
        while (k < 1600 && cyc < 20000) begin
          rt_out_ready = ($urandom_range(0, 3) != 0);
          if (mid_valid && mid_ready) begin
            total_cnt++; if (mid_last !== ((m % 16) == 15)) $display("FAIL rt_mid_last m=%0d: got %b want %b", m, mid_last, ((m % 16) == 15)); else pass_cnt++;
            m++;
          end
          if (rt_out_valid && rt_out_ready) begin
            total_cnt++; if (rt_out !== stim[k]) $display("FAIL rt_data k=%0d: got %h want %h", k, rt_out, stim[k]); else pass_cnt++;
            total_cnt++; if (rt_out_last !== ((k % 16) == 15)) $display("FAIL rt_last k=%0d: got %b want %b", k, rt_out_last, ((k % 16) == 15)); else pass_cnt++;
            k++;
          end
          @(negedge clk);
          cyc++;
        end
        rt_out_ready = 1'b1;
        total_cnt++; if (k !== 1600) $display("FAIL rt_count: got %0d bytes want 1600", k); else pass_cnt++;
      end
    join
    repeat (3) @(negedge clk);
    total_cnt++; if (rt_out_valid !== 1'b0) $display("FAIL rt_extra: got valid %b want 0", rt_out_valid); else pass_cnt++;
  endtask

  initial begin
    rst = 1'b1;
    din = 8'h00;
    din_valid = 1'b0;
    dout_ready = 1'b0;
    rt_din = 8'h00;
    rt_din_valid = 1'b0;
    rt_out_ready = 1'b0;
    test_reset();
    test_order();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_block();
    test_round_trip();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
